rw_reg_bank: RTL and testbench

Parametrised bank of software-accessible registers with per-register access mode, byte-lane write strobes, registered read port and hardware status inputs. It is the generalisation of the single read/write register. It sits between a simple register-access front end (WEN/REN strobes with addresses) and the datapath, which consumes `VALUE_OUT` and feeds `HW_IN`. It also signals write events, invalid-access errors and sticky status.

---
 rtl/rw_reg_bank.sv | 151 +++++++++++++++
 tb/tb_rw_reg_bank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rw_reg_bank.sv
// rw_reg_bank -- parametrised bank of software-accessible registers.
//
// Each register has its own access mode: RW, RO (hardware-driven), or
// W1C (sticky status). Writes use byte-lane strobes. The read port is
// registered. The bank also reports write events and invalid accesses.
//
// Parameters
//   DATA_WIDTH    register width, multiple of 8
//   NUM_REGS      implemented registers, 1..2**ADDR_WIDTH
//   ADDR_WIDTH    address width; addresses >= NUM_REGS are unmapped
//   REG_MODES     2 bits per register: 0 RW, 1 RO, 2 W1C, 3 reserved (RO)
//   RESET_VALUES  per-register reset value, register i at slice i
//
// Ports
//   CLK, RST          rising-edge clock, async active-high reset
//   WEN/WADDR/WDATA/WSTRB  write request
//   REN/RADDR         read request
//   RDATA/RVALID/RERR read response, one cycle after the request
//   WERR              pulse on a write to an unmapped or RO register
//   WR_PULSE          per-register pulse on an accepted write
//   HW_IN             RO value source / W1C per-bit set requests
//   VALUE_OUT         current register contents

// Single register with its update rule fixed by MODE.
module rw_reg_cell #(
  parameter int              DW      = 16,
  parameter logic [1:0]      MODE    = 2'd0,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_sel,
  input  logic [DW-1:0]    wdata,
  input  logic [DW/8-1:0]  wstrb,
  input  logic [DW-1:0]    hw_in,
  output logic [DW-1:0]    value
);
  logic [DW-1:0] bmask, wbits, nxt;

  // Expand byte strobes to a bit mask.
  for (genvar j = 0; j < DW; j++) begin : g_mask
    assign bmask[j] = wstrb[j/8];
  end
  assign wbits = wdata & bmask;

  always_comb begin
    nxt = value;
    case (MODE)
      2'd0: if (wr_sel) nxt = (value & ~bmask) | wbits;
      // Clear first, then OR in hardware sets so a same-cycle set wins.
      2'd2: nxt = (value & ~(wr_sel ? wbits : '0)) | hw_in;
      default: nxt = hw_in;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) value <= RST_VAL;
    else     value <= nxt;
  end
endmodule

module rw_reg_bank #(
  parameter int                               DATA_WIDTH   = 16,
  parameter int                               NUM_REGS     = 4,
  parameter int                               ADDR_WIDTH   = 3,
  parameter logic [2*NUM_REGS-1:0]            REG_MODES    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            WEN,
  input  logic [ADDR_WIDTH-1:0]           WADDR,
  input  logic [DATA_WIDTH-1:0]           WDATA,
  input  logic [DATA_WIDTH/8-1:0]         WSTRB,
  input  logic                            REN,
  input  logic [ADDR_WIDTH-1:0]           RADDR,
  output logic [DATA_WIDTH-1:0]           RDATA,
  output logic                            RVALID,
  output logic                            RERR,
  output logic                            WERR,
  output logic [NUM_REGS-1:0]             WR_PULSE,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]  HW_IN,
  output logic [NUM_REGS*DATA_WIDTH-1:0]  VALUE_OUT
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 reg_wr_ok;
  logic [NUM_REGS-1:0]                 wr_sel;
  logic                                werr_d;
  logic                                rd_hit;
  logic [DATA_WIDTH-1:0]               rd_val;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [1:0] MODE = REG_MODES[2*i +: 2];

    // Only RW and W1C registers accept software writes.
    assign reg_wr_ok[i] = (MODE == 2'd0) || (MODE == 2'd2);

    rw_reg_cell #(
      .DW      (DATA_WIDTH),
      .MODE    (MODE),
      .RST_VAL (RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .CLK    (CLK),
      .RST    (RST),
      .wr_sel (wr_sel[i]),
      .wdata  (WDATA),
      .wstrb  (WSTRB),
      .hw_in  (HW_IN[i*DATA_WIDTH +: DATA_WIDTH]),
      .value  (regs[i])
    );
  end

  assign VALUE_OUT = regs;

  // Address decode. An unmatched write address leaves werr_d = WEN,
  // so unmapped writes are flagged without an explicit range compare.
  always_comb begin
    werr_d = WEN;
    wr_sel = '0;
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (WADDR == ADDR_WIDTH'(i)) begin
        werr_d    = WEN && !reg_wr_ok[i];
        wr_sel[i] = WEN && reg_wr_ok[i] && (|WSTRB);
      end
      if (RADDR == ADDR_WIDTH'(i)) begin
        rd_hit = 1'b1;
        rd_val = regs[i];
      end
    end
  end

  // Read data samples the pre-edge contents, so a same-cycle write to the
  // same address returns the old value. RDATA holds when no read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDATA    <= '0;
      RVALID   <= 1'b0;
      RERR     <= 1'b0;
      WERR     <= 1'b0;
      WR_PULSE <= '0;
    end else begin
      RVALID   <= REN;
      RERR     <= REN && !rd_hit;
      if (REN) RDATA <= rd_hit ? rd_val : '0;
      WERR     <= werr_d;
      WR_PULSE <= wr_sel;
    end
  end
endmodule

// File: tb/tb_rw_reg_bank.sv
module tb_rw_reg_bank;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WEN = 1'b0;
  logic [2:0]  WADDR = '0;
  logic [15:0] WDATA = '0;
  logic [1:0]  WSTRB = '0;
  logic        REN = 1'b0;
  logic [2:0]  RADDR = '0;
  logic [15:0] RDATA;
  logic        RVALID, RERR, WERR;
  logic [3:0]  WR_PULSE;
  logic [63:0] HW_IN = '0;
  logic [63:0] VALUE_OUT;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  always #5 CLK = ~CLK;

  rw_reg_bank #(
    .DATA_WIDTH   (16),
    .NUM_REGS     (4),
    .ADDR_WIDTH   (3),
    .REG_MODES    (8'b10_01_00_00),
    .RESET_VALUES (64'h0000_0000_A5A5_0000)
  ) dut (
    .CLK(CLK), .RST(RST), .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA),
    .WSTRB(WSTRB), .REN(REN), .RADDR(RADDR), .RDATA(RDATA),
    .RVALID(RVALID), .RERR(RERR), .WERR(WERR), .WR_PULSE(WR_PULSE),
    .HW_IN(HW_IN), .VALUE_OUT(VALUE_OUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 RW, 1 RO, 2 W1C
  int          mode [4] = '{0, 0, 1, 2};
  logic [15:0] rstv [4] = '{16'h0000, 16'hA5A5, 16'h0000, 16'h0000};
  logic [15:0] m_val [4];
  logic [15:0] e_rdata;
  logic        e_rvalid, e_rerr, e_werr;
  logic [3:0]  e_wp;

  always @(posedge CLK or posedge RST) begin : model
    logic [15:0] nv [4];
    logic [15:0] bm, hw, clr;
    logic [3:0]  wp;
    logic        we;
    int          wa, ra;
    if (RST) begin
      m_val    <= rstv;
      e_rdata  <= '0;
      e_rvalid <= 1'b0;
      e_rerr   <= 1'b0;
      e_werr   <= 1'b0;
      e_wp     <= '0;
    end else begin
      bm = {{8{WSTRB[1]}}, {8{WSTRB[0]}}};
      wa = int'(WADDR);
      ra = int'(RADDR);
      wp = '0;
      we = 1'b0;
      if (WEN) begin
        if (wa > 3 || mode[wa] == 1) we = 1'b1;
        else if (WSTRB != 2'b00) wp[wa] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        hw = HW_IN[i*16 +: 16];
        if (mode[i] == 1) nv[i] = hw;
        else if (mode[i] == 2) begin
          clr = wp[i] ? (WDATA & bm) : 16'h0;
          nv[i] = (m_val[i] & ~clr) | hw;
        end else
          nv[i] = wp[i] ? ((m_val[i] & ~bm) | (WDATA & bm)) : m_val[i];
      end
      e_rvalid <= REN;
      if (REN) begin
        e_rdata <= (ra < 4) ? m_val[ra] : 16'h0;
        e_rerr  <= (ra >= 4);
      end
      e_werr <= we;
      e_wp   <= wp;
      m_val  <= nv;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("model_val%0d", i), {16'h0, VALUE_OUT[i*16 +: 16]}, {16'h0, m_val[i]});
      chk("model_rvalid", {31'h0, RVALID}, {31'h0, e_rvalid});
      chk("model_werr", {31'h0, WERR}, {31'h0, e_werr});
      chk("model_wrpulse", {28'h0, WR_PULSE}, {28'h0, e_wp});
      if (e_rvalid) begin
        chk("model_rdata", {16'h0, RDATA}, {16'h0, e_rdata});
        chk("model_rerr", {31'h0, RERR}, {31'h0, e_rerr});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // All drives happen just after a falling edge; literal checks follow
  // the next falling edge, i.e. in the cycle after the sampling edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] s);
    WEN = 1'b1; WADDR = a; WDATA = d; WSTRB = s;
    @(negedge CLK);
    WEN = 1'b0; WSTRB = '0;
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp,
                    input logic exp_err);
    REN = 1'b1; RADDR = a;
    @(negedge CLK);
    REN = 1'b0;
    chk({name, "_rvalid"}, {31'h0, RVALID}, 32'h1);
    chk({name, "_rdata"}, {16'h0, RDATA}, {16'h0, exp});
    chk({name, "_rerr"}, {31'h0, RERR}, {31'h0, exp_err});
  endtask

  function automatic logic [15:0] vo(input int i);
    return VALUE_OUT[i*16 +: 16];
  endfunction

  initial begin
    HW_IN = {16'h0000, 16'h1234, 16'h0000, 16'hDEAD};
    @(negedge CLK);
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_reg1", {16'h0, vo(1)}, 32'hA5A5);
    chk("rst_reg2", {16'h0, vo(2)}, 32'h0000);
    chk("rst_rvalid", {31'h0, RVALID}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);                       // RO reg picks up HW_IN here

    // Reset check
    rd("rst_rd0", 3'd0, 16'h0000, 1'b0);
    rd("rst_rd1", 3'd1, 16'hA5A5, 1'b0);
    rd("rst_rd2", 3'd2, 16'h1234, 1'b0);
    rd("rst_rd3", 3'd3, 16'h0000, 1'b0);

    // Byte strobes
    wr(3'd1, 16'h1234, 2'b01);
    chk("strb_lo", {16'h0, vo(1)}, 32'hA534);
    chk("strb_lo_pulse", {28'h0, WR_PULSE}, 32'h2);
    wr(3'd1, 16'hBEEF, 2'b10);
    chk("strb_hi", {16'h0, vo(1)}, 32'hBE34);
    chk("strb_hi_pulse", {28'h0, WR_PULSE}, 32'h2);
    @(negedge CLK);
    chk("strb_pulse_end", {28'h0, WR_PULSE}, 32'h0);
    wr(3'd0, 16'hFFFF, 2'b00);            // zero strobe: no effect, no error
    chk("strb0_pulse", {28'h0, WR_PULSE}, 32'h0);
    chk("strb0_werr", {31'h0, WERR}, 32'h0);
    chk("strb0_val", {16'h0, vo(0)}, 32'h0000);

    // W1C
    HW_IN[48 +: 16] = 16'h0081;
    @(negedge CLK);
    HW_IN[48 +: 16] = 16'h0000;
    chk("w1c_set", {16'h0, vo(3)}, 32'h0081);
    @(negedge CLK);
    chk("w1c_sticky", {16'h0, vo(3)}, 32'h0081);
    wr(3'd3, 16'h0001, 2'b11);
    chk("w1c_clr", {16'h0, vo(3)}, 32'h0080);
    HW_IN[48 +: 16] = 16'h0080;
    wr(3'd3, 16'h0080, 2'b11);
    HW_IN[48 +: 16] = 16'h0000;
    chk("w1c_setwins", {16'h0, vo(3)}, 32'h0080);
    chk("w1c_pulse", {28'h0, WR_PULSE}, 32'h8);

    // Invalid access
    wr(3'd2, 16'hFFFF, 2'b11);
    chk("inv_ro_werr", {31'h0, WERR}, 32'h1);
    chk("inv_ro_val", {16'h0, vo(2)}, 32'h1234);
    chk("inv_ro_pulse", {28'h0, WR_PULSE}, 32'h0);
    @(negedge CLK);
    chk("inv_werr_end", {31'h0, WERR}, 32'h0);
    wr(3'd6, 16'hFFFF, 2'b11);
    chk("inv_unmapped_werr", {31'h0, WERR}, 32'h1);
    rd("inv_rd5", 3'd5, 16'h0000, 1'b1);

    // Read during write
    wr(3'd0, 16'h1111, 2'b11);
    WEN = 1'b1; WADDR = 3'd0; WDATA = 16'h2222; WSTRB = 2'b11;
    rd("rdw_old", 3'd0, 16'h1111, 1'b0);
    WEN = 1'b0; WSTRB = '0;
    rd("rdw_new", 3'd0, 16'h2222, 1'b0);

    // Reset mid-operation: requests in flight when RST rises
    WEN = 1'b1; WADDR = 3'd0; WDATA = 16'h3333; WSTRB = 2'b11;
    REN = 1'b1; RADDR = 3'd1;
    #2 RST = 1'b1;
    @(negedge CLK);
    WEN = 1'b0; REN = 1'b0; WSTRB = '0;
    chk("mid_rvalid", {31'h0, RVALID}, 32'h0);
    chk("mid_werr", {31'h0, WERR}, 32'h0);
    chk("mid_pulse", {28'h0, WR_PULSE}, 32'h0);
    chk("mid_vals", VALUE_OUT[31:0], 32'hA5A5_0000);
    chk("mid_vals_hi", VALUE_OUT[63:32], 32'h0000_0000);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_ro", {16'h0, vo(2)}, 32'h1234);
    chk("post_rst_rvalid", {31'h0, RVALID}, 32'h0);
    rd("post_rst_rd0", 3'd0, 16'h0000, 1'b0);
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
